// File: rtl/fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arbiter_pkg
// Shared constants for the FIFO arbiter: FSM state encodings, default
// parameter values, the destination-field width, and a pointer-width helper.
// -----------------------------------------------------------------------------
package fifo_arbiter_pkg;

  // Default build parameters.
  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_NUM_FIFOS = 4;
  localparam int DEF_DEST_LSB  = 4;

  // Width of the destination field carried inside each word.
  localparam int DEST_W = 2;

  // FSM state encodings.
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POP   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Width of an index into n entries; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Round-robin priority picker: scans the request vector starting at index
// `ptr` and wrapping around, and grants the first active request found.
//
// Ports:
//   req   in  NUM_REQ  request vector (one bit per requester)
//   ptr   in  PTR_W    index with highest priority this cycle
//   grant out NUM_REQ  one-hot grant, all-zero when no request is active
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_arbiter
// Pops words from NUM_FIFOS input FIFOs in round-robin order and pushes each
// word into the output FIFO named by its 2-bit destination field. Two-stage
// pipeline: pop in cycle N, input-FIFO read data captured at the end of cycle
// N+1, push presented in cycle N+2. Popping stops while any output FIFO
// reports almost-full; up to two words already in flight are still pushed.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous, active-high reset
//   in_empty         in   NUM_FIFOS            empty flags of input FIFOs
//   in_data          in   NUM_FIFOS*WORD_SIZE  read data, FIFO i at [i*WORD_SIZE +: WORD_SIZE]
//   out_almost_full  in   NUM_FIFOS            almost-full flags of output FIFOs
//   out_full         in   NUM_FIFOS            full flags of output FIFOs
//   in_rd            out  NUM_FIFOS            one-hot pop strobe
//   out_wr           out  NUM_FIFOS            one-hot push strobe
//   data_out         out  WORD_SIZE            word being pushed
//   error            out  sticky: a push hit a full output FIFO
//   active           out  high while the FSM is not IDLE
//   word_count       out  16  saturating push counter (FIFO_ARBITER_STATS_EN only)
//
// Build option: define FIFO_ARBITER_STATS_EN to add the word_count output.
// -----------------------------------------------------------------------------
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int DEST_LSB  = DEF_DEST_LSB
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFOS-1:0]           in_empty,
  input  logic [NUM_FIFOS*WORD_SIZE-1:0] in_data,
  input  logic [NUM_FIFOS-1:0]           out_almost_full,
  input  logic [NUM_FIFOS-1:0]           out_full,
  output logic [NUM_FIFOS-1:0]           in_rd,
  output logic [NUM_FIFOS-1:0]           out_wr,
  output logic [WORD_SIZE-1:0]           data_out,
  output logic                           error,
  output logic                           active
`ifdef FIFO_ARBITER_STATS_EN
  ,
  output logic [15:0]                    word_count
`endif
);

  localparam int PTR_W = ptr_width(NUM_FIFOS);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_FIFOS-1:0] s1_sel_q, s1_sel_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [NUM_FIFOS-1:0] out_wr_q, out_wr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 error_q, error_d;

  logic [NUM_FIFOS-1:0] grant;
  logic [WORD_SIZE-1:0] s1_word;
  logic [DEST_W-1:0]    s1_dest;
  logic                 any_req, any_af, drained;

  assign any_req = |(~in_empty);
  assign any_af  = |out_almost_full;
  assign drained = !s1_valid_q && !s2_valid_q;

  rr_priority_picker #(
    .NUM_REQ (NUM_FIFOS),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (~in_empty),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Pops only happen in POP; the picker already excludes empty inputs.
  assign in_rd = (state_q == ST_POP) ? grant : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req && !any_af)      state_d = ST_POP;
      ST_POP:   if (any_af)                  state_d = ST_STALL;
                else if (!any_req && drained) state_d = ST_IDLE;
      ST_STALL: if (!any_af && any_req)      state_d = ST_POP;
                else if (!any_req && drained) state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Pointer moves to the input after the one just granted and otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (in_rd[i]) ptr_d = (i == NUM_FIFOS - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // Stage 1 remembers which input was popped; its read data arrives one
  // cycle after the pop and is selected here.
  always_comb begin
    s1_valid_d = |in_rd;
    s1_sel_d   = in_rd;
    s1_word    = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (s1_sel_q[i]) s1_word = s1_word | in_data[i*WORD_SIZE +: WORD_SIZE];
    end
    s1_dest = s1_word[DEST_LSB +: DEST_W];
  end

  // Stage 2 registers the word and decodes its destination into the push.
  always_comb begin
    s2_valid_d = s1_valid_q;
    data_d     = s1_valid_q ? s1_word : data_q;
    out_wr_d   = '0;
    if (s1_valid_q) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (int'(s1_dest) == i) out_wr_d[i] = 1'b1;
      end
    end
    // Overflow is only flagged; the push itself is not suppressed.
    error_d = error_q | (|(out_wr_q & out_full));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      out_wr_q   <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      out_wr_q   <= out_wr_d;
      data_q     <= data_d;
      error_q    <= error_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign data_out = data_q;
  assign error    = error_q;
  assign active   = (state_q != ST_IDLE);

`ifdef FIFO_ARBITER_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (|out_wr_q && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign word_count = count_q;
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_arbiter
// Directed bench for fifo_arbiter with a behavioural model of the input FIFOs
// (read data appears the cycle after a pop). Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_arbiter;

  localparam int W = 6;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   out_almost_full = '0;
  logic [N-1:0]   out_full = '0;
  logic [N-1:0]   in_rd;
  logic [N-1:0]   out_wr;
  logic [W-1:0]   data_out;
  logic           error;
  logic           active;
`ifdef FIFO_ARBITER_STATS_EN
  logic [15:0]    word_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .in_rd           (in_rd),
    .out_wr          (out_wr),
    .data_out        (data_out),
    .error           (error),
    .active          (active)
`ifdef FIFO_ARBITER_STATS_EN
    ,
    .word_count      (word_count)
`endif
  );

  // Input FIFO model: 16-deep circular store per input.
  logic [W-1:0] mem [N][16];
  int           rd_ptr [N] = '{default: 0};
  int           wr_cnt [N] = '{default: 0};
  logic [W-1:0] dreg   [N] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (in_rd[i]) begin
        dreg[i]   <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_empty[i]      = (rd_ptr[i] == wr_cnt[i]);
      in_data[i*W +: W] = dreg[i];
    end
  end

  task automatic load(input int i, input logic [W-1:0] w);
    mem[i][wr_cnt[i] % 16] = w;
    wr_cnt[i] = wr_cnt[i] + 1;
  endtask

  // Advance to the next falling edge; a pop of an empty input is always wrong.
  task automatic tick();
    @(negedge clk);
    total++;
    if ((in_rd & in_empty) !== '0) begin
      bad++;
      $display("FAIL pop_of_empty in_rd=%b in_empty=%b", in_rd, in_empty);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (in_rd !== 4'b0)    begin bad++; $display("FAIL rst_in_rd got=%b exp=0000", in_rd); end
    total++; if (out_wr !== 4'b0)   begin bad++; $display("FAIL rst_out_wr got=%b exp=0000", out_wr); end
    total++; if (data_out !== 6'b0) begin bad++; $display("FAIL rst_data_out got=%h exp=00", data_out); end
    total++; if (error !== 1'b0)    begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    total++; if (active !== 1'b0)   begin bad++; $display("FAIL rst_active got=%b exp=0", active); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (in_rd !== 4'b0)  begin bad++; $display("FAIL idle_in_rd cyc=%0d got=%b exp=0000", c, in_rd); end
      total++; if (out_wr !== 4'b0) begin bad++; $display("FAIL idle_out_wr cyc=%0d got=%b exp=0000", c, out_wr); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL idle_active cyc=%0d got=%b exp=0", c, active); end
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_word [8] = '{6'b00_0001, 6'b10_0101, 6'b11_0010, 6'b01_0111,
                                   6'b01_1000, 6'b00_1001, 6'b10_1110, 6'b11_1111};
    logic [N-1:0] exp_wr [8] = '{4'b0001, 4'b0100, 4'b1000, 4'b0010,
                                 4'b0010, 4'b0001, 4'b0100, 4'b1000};
    logic [N-1:0] exp_rd [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [N-1:0] rec_rd [20];
    logic [N-1:0] rec_wr [20];
    logic [W-1:0] rec_do [20];
    int c0;
    for (int k = 0; k < 8; k++) load(k % 4, exp_word[k]);
    for (int c = 0; c < 20; c++) begin
      tick();
      rec_rd[c] = in_rd;
      rec_wr[c] = out_wr;
      rec_do[c] = data_out;
    end
    c0 = -1;
    for (int c = 0; c < 20; c++) if (c0 < 0 && rec_rd[c] !== 4'b0) c0 = c;
    total++;
    if (c0 < 0 || c0 > 10) begin
      bad++; $display("FAIL rr_first_grant got_cycle=%0d exp<=10", c0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++; if (rec_rd[c0+k] !== exp_rd[k])     begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, rec_rd[c0+k], exp_rd[k]); end
        total++; if (rec_wr[c0+k+2] !== exp_wr[k])   begin bad++; $display("FAIL rr_push k=%0d got=%b exp=%b", k, rec_wr[c0+k+2], exp_wr[k]); end
        total++; if (rec_do[c0+k+2] !== exp_word[k]) begin bad++; $display("FAIL rr_data k=%0d got=%b exp=%b", k, rec_do[c0+k+2], exp_word[k]); end
      end
      total++; if (rec_rd[c0+8] !== 4'b0) begin bad++; $display("FAIL rr_grant_after_empty got=%b exp=0000", rec_rd[c0+8]); end
      total++; if (rec_wr[c0+10] !== 4'b0) begin bad++; $display("FAIL rr_push_after_drain got=%b exp=0000", rec_wr[c0+10]); end
      // Word 10_0101 from input 1 routes to output 2.
      total++; if (rec_do[c0+3] !== 6'b10_0101 || rec_wr[c0+3] !== 4'b0100) begin
        bad++; $display("FAIL dest_route got=%b/%b exp=100101/0100", rec_do[c0+3], rec_wr[c0+3]);
      end
    end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rr_back_to_idle got=%b exp=0", active); end
  endtask

  task automatic test_stall();
    logic hit;
    int   pushes;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) load(i, {i[1:0], j[3:0]});
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (in_rd !== 4'b0) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL stall_start timeout got=%b exp=0001", in_rd);
    end else begin
      total++; if (in_rd !== 4'b0001) begin bad++; $display("FAIL stall_g0 got=%b exp=0001", in_rd); end
      tick();
      total++; if (in_rd !== 4'b0010) begin bad++; $display("FAIL stall_g1 got=%b exp=0010", in_rd); end
      tick();
      total++; if (in_rd !== 4'b0100) begin bad++; $display("FAIL stall_g2 got=%b exp=0100", in_rd); end
      out_almost_full = 4'b0100;
      pushes = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (out_wr !== 4'b0) pushes++;
        total++; if (in_rd !== 4'b0) begin bad++; $display("FAIL stall_in_rd cyc=%0d got=%b exp=0000", c, in_rd); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL stall_active cyc=%0d got=%b exp=1", c, active); end
      end
      total++; if (pushes != 2) begin bad++; $display("FAIL stall_inflight_pushes got=%0d exp=2", pushes); end
      out_almost_full = 4'b0000;
      tick();
      total++; if (in_rd !== 4'b1000) begin bad++; $display("FAIL stall_resume got=%b exp=1000", in_rd); end
    end
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      tick();
      if (active === 1'b0) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL stall_drain timeout active=%b exp=0", active); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL stall_error got=%b exp=0", error); end
  endtask

  task automatic test_error();
    logic hit;
    out_full = 4'b1000;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", error); end
    load(1, 6'b11_0000);
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (out_wr !== 4'b0) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL err_push timeout got=%b exp=1000", out_wr);
    end else begin
      total++; if (out_wr !== 4'b1000)      begin bad++; $display("FAIL err_push_dest got=%b exp=1000", out_wr); end
      total++; if (data_out !== 6'b11_0000) begin bad++; $display("FAIL err_push_data got=%b exp=110000", data_out); end
      tick();
      total++; if (error !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", error); end
    end
    out_full = 4'b0000;
    repeat (5) tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error); end
    reset = 1'b1;
    #1;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared_by_reset got=%b exp=0", error); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic hit;
    for (int i = 0; i < N; i++) begin
      load(i, 6'b00_0110);
      load(i, 6'b01_0011);
    end
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      tick();
      if (in_rd !== 4'b0) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rstmid_start timeout in_rd=%b", in_rd); end
    tick();
    reset = 1'b1;
    #1;
    total++; if (in_rd !== 4'b0)    begin bad++; $display("FAIL rstmid_in_rd got=%b exp=0000", in_rd); end
    total++; if (out_wr !== 4'b0)   begin bad++; $display("FAIL rstmid_out_wr got=%b exp=0000", out_wr); end
    total++; if (data_out !== 6'b0) begin bad++; $display("FAIL rstmid_data got=%b exp=000000", data_out); end
    total++; if (active !== 1'b0)   begin bad++; $display("FAIL rstmid_active got=%b exp=0", active); end
    for (int i = 0; i < N; i++) wr_cnt[i] = rd_ptr[i];
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (out_wr !== 4'b0) begin bad++; $display("FAIL rstmid_ghost_push cyc=%0d got=%b exp=0000", c, out_wr); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL rstmid_idle cyc=%0d got=%b exp=0", c, active); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_round_robin();
    test_stall();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
